// File: rtl/fb_pipe_skidreg_pkg.sv
// Shared definitions for the fb_pipe_skidreg pipeline-stage register.
// Contents:
//   - default field widths for the EX/MEM instance of the stage
//   - bit offsets for unpacking the EX/MEM control field
//   - the per-edge action encoding and the function that selects it
package fb_pipe_skidreg_pkg;

  localparam int FB_EXMEM_CTRL_W = 5;
  localparam int FB_EXMEM_DATA_W = 69;  // alu_res 32 + rs2_data 32 + rd 5
  localparam int FB_STALLCNT_W   = 16;

  // Bit positions inside the EX/MEM control field
  localparam int FB_CTRL_MEM_READ   = 0;
  localparam int FB_CTRL_MEM_WRITE  = 1;
  localparam int FB_CTRL_BRANCH     = 2;
  localparam int FB_CTRL_MEM_TO_REG = 3;
  localparam int FB_CTRL_REG_WRITE  = 4;

  // What the stage does on the next rising edge, highest priority first
  typedef enum logic [1:0] {
    ACT_FLUSH     = 2'd0,  // kill everything held and incoming
    ACT_SKID2MAIN = 2'd1,  // main drains, refilled from the skid entry
    ACT_LOAD      = 2'd2,  // main drains, refilled from the input (or bubble)
    ACT_HOLD      = 2'd3   // main is stuck; a new input parks in the skid
  } stage_act_e;

  function automatic stage_act_e sel_action(input logic flush,
                                            input logic drain,
                                            input logic skid_vld);
    if (flush) begin
      return ACT_FLUSH;
    end else if (drain && skid_vld) begin
      return ACT_SKID2MAIN;
    end else if (drain) begin
      return ACT_LOAD;
    end else begin
      return ACT_HOLD;
    end
  endfunction

endpackage

// File: rtl/fb_pipe_skidreg_if.sv
// Valid/ready handshake bundle carrying a control field and a data field.
// Ports (modports):
//   master : drives valid, ctrl, data; receives ready
//   slave  : receives valid, ctrl, data; drives ready
interface fb_pipe_skidreg_if
  import fb_pipe_skidreg_pkg::*;
#(
  parameter int CTRL_W = FB_EXMEM_CTRL_W,
  parameter int DATA_W = FB_EXMEM_DATA_W
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);
endinterface

// File: rtl/fb_pipe_skidreg_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   inc      : add one this edge (ignored once at the maximum value)
//   clr      : synchronous clear, wins over inc
//   cnt      : registered count value
module fb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear first, then increment until saturated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
endmodule

// File: rtl/fb_pipe_skidreg.sv
// Pipeline-stage register with valid/ready handshake and a 2-entry skid
// buffer (main + skid), synchronous flush and a saturating stall counter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous kill of held and incoming entries
//   up         : upstream handshake (slave side); up.ready is a flop output
//   dn         : downstream handshake (master side); dn.ctrl is 0 when !dn.valid
//   stall_cnt  : cycles with dn.valid=1 and dn.ready=0, saturating
//   stall_clr  : synchronous clear of stall_cnt
module fb_pipe_skidreg
  import fb_pipe_skidreg_pkg::*;
#(
  parameter int CTRL_W = FB_EXMEM_CTRL_W,
  parameter int DATA_W = FB_EXMEM_DATA_W,
  parameter int CNT_W  = FB_STALLCNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  fb_pipe_skidreg_if.slave   up,
  fb_pipe_skidreg_if.master  dn,
  output logic [CNT_W-1:0]   stall_cnt,
  input  logic               stall_clr
);
  logic              main_vld_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [DATA_W-1:0] main_data_r;
  logic              skid_vld_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [DATA_W-1:0] skid_data_r;
  // Kept as its own flop (always ~skid_vld_r) so up.ready never depends
  // combinationally on dn.ready.
  logic              in_ready_r;

  logic       acc_s;
  logic       drain_s;
  stage_act_e act_s;

  // Handshake decode and edge action selection
  always_comb begin
    acc_s   = up.valid & in_ready_r;
    drain_s = ~main_vld_r | dn.ready;
    act_s   = sel_action(flush, drain_s, skid_vld_r);
  end

  // Main/skid storage. Control bits of an emptied slot are zeroed so the
  // output presents a clean bubble; data is left holding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_vld_r  <= 1'b0;
      main_ctrl_r <= '0;
      main_data_r <= '0;
      skid_vld_r  <= 1'b0;
      skid_ctrl_r <= '0;
      skid_data_r <= '0;
      in_ready_r  <= 1'b1;
    end else begin
      case (act_s)
        ACT_FLUSH: begin
          main_vld_r  <= 1'b0;
          main_ctrl_r <= '0;
          skid_vld_r  <= 1'b0;
          skid_ctrl_r <= '0;
          in_ready_r  <= 1'b1;
        end
        ACT_SKID2MAIN: begin
          // in_ready_r is 0 here, so no input can be accepted alongside
          main_vld_r  <= 1'b1;
          main_ctrl_r <= skid_ctrl_r;
          main_data_r <= skid_data_r;
          skid_vld_r  <= 1'b0;
          in_ready_r  <= 1'b1;
        end
        ACT_LOAD: begin
          main_vld_r <= acc_s;
          if (acc_s) begin
            main_ctrl_r <= up.ctrl;
            main_data_r <= up.data;
          end else begin
            main_ctrl_r <= '0;
          end
          in_ready_r <= 1'b1;
        end
        ACT_HOLD: begin
          if (acc_s) begin
            skid_vld_r  <= 1'b1;
            skid_ctrl_r <= up.ctrl;
            skid_data_r <= up.data;
            in_ready_r  <= 1'b0;
          end else begin
            in_ready_r  <= ~skid_vld_r;
          end
        end
        default: begin
          in_ready_r <= ~skid_vld_r;
        end
      endcase
    end
  end

  fb_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (main_vld_r & ~dn.ready),
    .clr (stall_clr),
    .cnt (stall_cnt)
  );

  assign up.ready = in_ready_r;
  assign dn.valid = main_vld_r;
  assign dn.ctrl  = main_ctrl_r;
  assign dn.data  = main_data_r;
endmodule

// File: tb/tb_fb_pipe_skidreg.sv
module tb_fb_pipe_skidreg;
  localparam int CW = 5;
  localparam int DW = 69;
  localparam int NW = 4;
  localparam int SAT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic stall_clr = 1'b0;
  logic [NW-1:0] stall_cnt;

  fb_pipe_skidreg_if #(.CTRL_W(CW), .DATA_W(DW)) up_if ();
  fb_pipe_skidreg_if #(.CTRL_W(CW), .DATA_W(DW)) dn_if ();

  fb_pipe_skidreg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two entries
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;
  ent_t          q[$];
  int            m_stall = 0;
  logic [DW-1:0] m_data = '0;
  logic          m_acc;
  logic          m_had;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_stall = 0;
      m_data  = '0;
    end else begin
      m_acc = up_if.valid && (q.size() < 2);
      m_had = (q.size() > 0);
      if (stall_clr) m_stall = 0;
      else if (m_had && !dn_if.ready && m_stall < SAT) m_stall = m_stall + 1;
      if (flush) begin
        q.delete();
      end else begin
        if (m_had && dn_if.ready) void'(q.pop_front());
        if (m_acc) q.push_back('{c: up_if.ctrl, d: up_if.data});
      end
      if (q.size() > 0) m_data = q[0].d;
    end
  end

  // Compare DUT outputs against the model every cycle, away from the edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("m_out_valid", DW'(dn_if.valid), DW'(q.size() > 0));
      chk("m_out_ctrl", DW'(dn_if.ctrl), (q.size() > 0) ? DW'(q[0].c) : '0);
      chk("m_out_data", dn_if.data, m_data);
      chk("m_in_ready", DW'(up_if.ready), DW'(q.size() < 2));
      chk("m_stall_cnt", DW'(stall_cnt), DW'(m_stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    up_if.valid = v;
    up_if.ctrl  = c;
    up_if.data  = d;
  endtask

  logic [95:0] rnd;
  logic [31:0] rc;

  initial begin
    drive(1'b0, '0, '0);
    dn_if.ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    tick();
    chk("rst_valid", DW'(dn_if.valid), DW'(1'b0));
    chk("rst_ctrl", DW'(dn_if.ctrl), '0);
    chk("rst_data", dn_if.data, '0);
    chk("rst_in_ready", DW'(up_if.ready), DW'(1'b1));
    chk("rst_stall", DW'(stall_cnt), '0);

    // Streaming at full rate
    dn_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'b10101, DW'(i));
      tick();
      chk("stream_data", dn_if.data, DW'(i));
      chk("stream_ctrl", DW'(dn_if.ctrl), DW'(5'b10101));
      chk("stream_in_ready", DW'(up_if.ready), DW'(1'b1));
    end
    drive(1'b0, '0, '0);
    tick();
    chk("stream_end_valid", DW'(dn_if.valid), DW'(1'b0));
    chk("stream_stall", DW'(stall_cnt), '0);

    // Back-pressure fills main then skid
    dn_if.ready = 1'b0;
    drive(1'b1, 5'd1, 69'hA);
    tick();
    chk("bp_a_main", dn_if.data, 69'hA);
    drive(1'b1, 5'd2, 69'hB);
    tick();
    chk("bp_full_ready", DW'(up_if.ready), DW'(1'b0));
    drive(1'b1, 5'd3, 69'hC);
    tick();
    chk("bp_stall2", DW'(stall_cnt), DW'(2));
    chk("bp_a_hold", dn_if.data, 69'hA);
    dn_if.ready = 1'b1;
    tick();
    chk("bp_b_out", dn_if.data, 69'hB);
    chk("bp_ready_back", DW'(up_if.ready), DW'(1'b1));
    tick();
    chk("bp_c_out", dn_if.data, 69'hC);
    chk("bp_c_ctrl", DW'(dn_if.ctrl), DW'(5'd3));
    drive(1'b0, '0, '0);
    tick();
    chk("bp_empty", DW'(dn_if.valid), DW'(1'b0));

    // Flush with two entries held and an incoming D
    dn_if.ready = 1'b0;
    drive(1'b1, 5'd4, 69'h11);
    tick();
    drive(1'b1, 5'd5, 69'h22);
    tick();
    drive(1'b1, 5'd6, 69'hD);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_valid", DW'(dn_if.valid), DW'(1'b0));
    chk("fl_ctrl", DW'(dn_if.ctrl), '0);
    chk("fl_in_ready", DW'(up_if.ready), DW'(1'b1));
    dn_if.ready = 1'b1;
    repeat (3) tick();
    chk("fl_no_d", DW'(dn_if.valid), DW'(1'b0));

    // Flush coinciding with a downstream handshake, then accept F
    drive(1'b1, 5'd7, 69'hE);
    tick();
    chk("fe_e_out", dn_if.data, 69'hE);
    drive(1'b0, '0, '0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fe_empty", DW'(dn_if.valid), DW'(1'b0));
    drive(1'b1, 5'd8, 69'hF);
    tick();
    chk("fe_f_out", dn_if.data, 69'hF);
    chk("fe_f_valid", DW'(dn_if.valid), DW'(1'b1));
    drive(1'b0, '0, '0);
    tick();

    // Asynchronous reset with two entries held
    dn_if.ready = 1'b0;
    drive(1'b1, 5'd9, 69'h31);
    tick();
    drive(1'b1, 5'd10, 69'h32);
    tick();
    drive(1'b0, '0, '0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", DW'(dn_if.valid), DW'(1'b0));
    chk("arst_ctrl", DW'(dn_if.ctrl), '0);
    chk("arst_data", dn_if.data, '0);
    chk("arst_in_ready", DW'(up_if.ready), DW'(1'b1));
    chk("arst_stall", DW'(stall_cnt), '0);
    #3 rst = 1'b0;
    tick();

    // Stall counter saturation and clear priority
    drive(1'b1, 5'd11, 69'h5);
    tick();
    drive(1'b0, '0, '0);
    repeat (20) tick();
    chk("sat_15", DW'(stall_cnt), DW'(SAT));
    stall_clr = 1'b1;
    tick();
    chk("sat_clr", DW'(stall_cnt), '0);
    tick();
    chk("clr_vs_stall", DW'(stall_cnt), '0);
    stall_clr = 1'b0;
    tick();
    chk("sat_restart", DW'(stall_cnt), DW'(1));
    dn_if.ready = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rnd = {$urandom, $urandom, $urandom};
      rc  = $urandom;
      drive(($urandom_range(0, 2) != 0), rc[4:0], rnd[DW-1:0]);
      dn_if.ready = (n % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      stall_clr   = ($urandom_range(0, 63) == 0);
      tick();
    end
    drive(1'b0, '0, '0);
    flush = 1'b0;
    stall_clr = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
